// File: rtl/id_ex_operand_stage_if.sv
// ID->EX operand stage bus: ID instruction fields, forwarding sources, pipeline control and EX-side results.
// Signal suffixes are named from the stage's point of view (slave modport).
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int SA_W   = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic              id_ready_o;
    logic [REG_AW-1:0] id_rs_addr_i;
    logic [REG_AW-1:0] id_rt_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic              id_rs_used_i;
    logic              id_rt_used_i;
    logic [SA_W-1:0]   id_sa_i;
    logic [DATA_W-1:0] id_imm_i;
    logic              id_op1_src_i;
    logic              id_op2_src_i;
    logic [1:0]        id_dst_src_i;
    logic [1:0]        id_wdata_src_i;
    logic              id_reg_wen_i;

    logic              ex_fwd_wen_i;
    logic [REG_AW-1:0] ex_fwd_addr_i;
    logic [DATA_W-1:0] ex_fwd_data_i;
    logic              ex_fwd_is_load_i;
    logic              mem_fwd_wen_i;
    logic [REG_AW-1:0] mem_fwd_addr_i;
    logic [DATA_W-1:0] mem_fwd_data_i;
    logic              wb_fwd_wen_i;
    logic [REG_AW-1:0] wb_fwd_addr_i;
    logic [DATA_W-1:0] wb_fwd_data_i;

    logic              ex_hold_i;
    logic              flush_i;

    logic              ex_valid_o;
    logic [DATA_W-1:0] ex_opnd1_o;
    logic [DATA_W-1:0] ex_opnd2_o;
    logic [DATA_W-1:0] ex_store_data_o;
    logic [REG_AW-1:0] ex_reg_dst_o;
    logic              ex_reg_wen_o;
    logic [1:0]        ex_wdata_src_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
        input  id_rs_data_i, id_rt_data_i, id_rs_used_i, id_rt_used_i,
        input  id_sa_i, id_imm_i, id_op1_src_i, id_op2_src_i,
        input  id_dst_src_i, id_wdata_src_i, id_reg_wen_i,
        input  ex_fwd_wen_i, ex_fwd_addr_i, ex_fwd_data_i, ex_fwd_is_load_i,
        input  mem_fwd_wen_i, mem_fwd_addr_i, mem_fwd_data_i,
        input  wb_fwd_wen_i, wb_fwd_addr_i, wb_fwd_data_i,
        input  ex_hold_i, flush_i,
        output id_ready_o,
        output ex_valid_o, ex_opnd1_o, ex_opnd2_o, ex_store_data_o,
        output ex_reg_dst_o, ex_reg_wen_o, ex_wdata_src_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
        output id_rs_data_i, id_rt_data_i, id_rs_used_i, id_rt_used_i,
        output id_sa_i, id_imm_i, id_op1_src_i, id_op2_src_i,
        output id_dst_src_i, id_wdata_src_i, id_reg_wen_i,
        output ex_fwd_wen_i, ex_fwd_addr_i, ex_fwd_data_i, ex_fwd_is_load_i,
        output mem_fwd_wen_i, mem_fwd_addr_i, mem_fwd_data_i,
        output wb_fwd_wen_i, wb_fwd_addr_i, wb_fwd_data_i,
        output ex_hold_i, flush_i,
        input  id_ready_o,
        input  ex_valid_o, ex_opnd1_o, ex_opnd2_o, ex_store_data_o,
        input  ex_reg_dst_o, ex_reg_wen_o, ex_wdata_src_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// Registered ID->EX operand-select stage: forwarding (EX > MEM > WB > regfile),
// load-use bubble insertion and EX-stage registers under hold/flush control.
module id_ex_operand_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int SA_W      = 5,
    parameter int SA_SIGNED = 0,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    id_ex_operand_stage_if.slave    bus
);
    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_R31  = 2'b10;

    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_wen,
        input logic [REG_AW-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_data,
        input logic              mem_wen,
        input logic [REG_AW-1:0] mem_addr,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_wen,
        input logic [REG_AW-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] res;
        if (addr == '0)
            res = '0;
        else if (ex_wen && ex_addr == addr)
            res = ex_data;
        else if (mem_wen && mem_addr == addr)
            res = mem_data;
        else if (wb_wen && wb_addr == addr)
            res = wb_data;
        else
            res = rf_data;
        return res;
    endfunction

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] sa_ext;
    logic [DATA_W-1:0] opnd1_sel;
    logic [DATA_W-1:0] opnd2_sel;
    logic [REG_AW-1:0] dst_sel;
    logic              wen_sel;
    logic              load_hz;

    assign fwd_rs = fwd_pick(bus.id_rs_addr_i, bus.id_rs_data_i,
                             bus.ex_fwd_wen_i, bus.ex_fwd_addr_i, bus.ex_fwd_data_i,
                             bus.mem_fwd_wen_i, bus.mem_fwd_addr_i, bus.mem_fwd_data_i,
                             bus.wb_fwd_wen_i, bus.wb_fwd_addr_i, bus.wb_fwd_data_i);
    assign fwd_rt = fwd_pick(bus.id_rt_addr_i, bus.id_rt_data_i,
                             bus.ex_fwd_wen_i, bus.ex_fwd_addr_i, bus.ex_fwd_data_i,
                             bus.mem_fwd_wen_i, bus.mem_fwd_addr_i, bus.mem_fwd_data_i,
                             bus.wb_fwd_wen_i, bus.wb_fwd_addr_i, bus.wb_fwd_data_i);

    generate
        if (SA_SIGNED != 0) begin : g_sa_sext
            assign sa_ext = {{(DATA_W-SA_W){bus.id_sa_i[SA_W-1]}}, bus.id_sa_i};
        end else begin : g_sa_zext
            assign sa_ext = {{(DATA_W-SA_W){1'b0}}, bus.id_sa_i};
        end
    endgenerate

    assign opnd1_sel = bus.id_op1_src_i ? sa_ext : fwd_rs;
    assign opnd2_sel = bus.id_op2_src_i ? bus.id_imm_i : fwd_rt;

    always_comb begin
        dst_sel = '0;
        wen_sel = 1'b0;
        case (bus.id_dst_src_i)
            DST_RT:  begin dst_sel = bus.id_rt_addr_i; wen_sel = bus.id_reg_wen_i; end
            DST_RD:  begin dst_sel = bus.id_rd_addr_i; wen_sel = bus.id_reg_wen_i; end
            DST_R31: begin dst_sel = REG_AW'(31);      wen_sel = bus.id_reg_wen_i; end
            default: begin dst_sel = '0;               wen_sel = 1'b0;             end
        endcase
    end

    // A load in EX has no data yet; any ID read of its destination must wait one cycle.
    assign load_hz = bus.id_valid_i && bus.ex_fwd_wen_i && bus.ex_fwd_is_load_i &&
                     (bus.ex_fwd_addr_i != '0) &&
                     ((bus.id_rs_used_i && bus.id_rs_addr_i == bus.ex_fwd_addr_i) ||
                      (bus.id_rt_used_i && bus.id_rt_addr_i == bus.ex_fwd_addr_i));

    assign bus.id_ready_o = !rst && (bus.flush_i || (!bus.ex_hold_i && !load_hz));

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] opnd1_q,  opnd1_d;
    logic [DATA_W-1:0] opnd2_q,  opnd2_d;
    logic [DATA_W-1:0] sdata_q,  sdata_d;
    logic [REG_AW-1:0] dst_q,    dst_d;
    logic              rwen_q,   rwen_d;
    logic [1:0]        wsrc_q,   wsrc_d;
    logic [CNT_W-1:0]  stall_q,  stall_d;

    always_comb begin
        valid_d = valid_q;
        opnd1_d = opnd1_q;
        opnd2_d = opnd2_q;
        sdata_d = sdata_q;
        dst_d   = dst_q;
        rwen_d  = rwen_q;
        wsrc_d  = wsrc_q;
        stall_d = stall_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (bus.ex_hold_i) begin
            valid_d = valid_q;
        end else if (load_hz) begin
            valid_d = 1'b0;
            if (stall_q != {CNT_W{1'b1}})
                stall_d = stall_q + CNT_W'(1);
        end else begin
            valid_d = bus.id_valid_i;
            opnd1_d = opnd1_sel;
            opnd2_d = opnd2_sel;
            sdata_d = fwd_rt;
            dst_d   = dst_sel;
            rwen_d  = wen_sel;
            wsrc_d  = bus.id_wdata_src_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            opnd1_q <= '0;
            opnd2_q <= '0;
            sdata_q <= '0;
            dst_q   <= '0;
            rwen_q  <= 1'b0;
            wsrc_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            opnd1_q <= opnd1_d;
            opnd2_q <= opnd2_d;
            sdata_q <= sdata_d;
            dst_q   <= dst_d;
            rwen_q  <= rwen_d;
            wsrc_q  <= wsrc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.ex_valid_o      = valid_q;
    assign bus.ex_opnd1_o      = opnd1_q;
    assign bus.ex_opnd2_o      = opnd2_q;
    assign bus.ex_store_data_o = sdata_q;
    assign bus.ex_reg_dst_o    = dst_q;
    assign bus.ex_reg_wen_o    = rwen_q;
    assign bus.ex_wdata_src_o  = wsrc_q;
    assign bus.stall_cnt_o     = stall_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, hand-written stall/hold/flush sequences and
// random traffic against a behavioural model. Two instances: zero-extended sa / 16-bit counter, sign-extended sa / 2-bit counter.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5), .SA_W(5), .CNT_W(16)) bus0 ();
    id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5), .SA_W(5), .CNT_W(2))  bus1 ();

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .SA_W(5), .SA_SIGNED(0), .CNT_W(16))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .SA_W(5), .SA_SIGNED(1), .CNT_W(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_d, rt_d;
        logic        rs_used, rt_used;
        logic [4:0]  sa;
        logic [31:0] imm;
        logic        op1_src, op2_src;
        logic [1:0]  dst_src, wsrc;
        logic        reg_wen;
        logic        ex_wen;  logic [4:0] ex_addr;  logic [31:0] ex_data; logic ex_load;
        logic        mem_wen; logic [4:0] mem_addr; logic [31:0] mem_data;
        logic        wb_wen;  logic [4:0] wb_addr;  logic [31:0] wb_data;
        logic        hold, flush;
    } stim_t;

    stim_t s;

`define DRIVE(b) \
        b.id_valid_i = s.valid;     b.id_rs_addr_i = s.rs;      b.id_rt_addr_i = s.rt; \
        b.id_rd_addr_i = s.rd;      b.id_rs_data_i = s.rs_d;    b.id_rt_data_i = s.rt_d; \
        b.id_rs_used_i = s.rs_used; b.id_rt_used_i = s.rt_used; b.id_sa_i = s.sa; \
        b.id_imm_i = s.imm;         b.id_op1_src_i = s.op1_src; b.id_op2_src_i = s.op2_src; \
        b.id_dst_src_i = s.dst_src; b.id_wdata_src_i = s.wsrc;  b.id_reg_wen_i = s.reg_wen; \
        b.ex_fwd_wen_i = s.ex_wen;  b.ex_fwd_addr_i = s.ex_addr; b.ex_fwd_data_i = s.ex_data; \
        b.ex_fwd_is_load_i = s.ex_load; \
        b.mem_fwd_wen_i = s.mem_wen; b.mem_fwd_addr_i = s.mem_addr; b.mem_fwd_data_i = s.mem_data; \
        b.wb_fwd_wen_i = s.wb_wen;  b.wb_fwd_addr_i = s.wb_addr; b.wb_fwd_data_i = s.wb_data; \
        b.ex_hold_i = s.hold;       b.flush_i = s.flush;

    always_comb begin
        `DRIVE(bus0)
        `DRIVE(bus1)
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_op1 = '0, m_op1s = '0, m_op2 = '0, m_sd = '0;
    logic [4:0]  m_dst = '0;
    logic        m_wen = 1'b0;
    logic [1:0]  m_wsrc = '0;
    int          m_cnt0 = 0, m_cnt1 = 0;

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (s.ex_wen  && s.ex_addr  == a) return s.ex_data;
        if (s.mem_wen && s.mem_addr == a) return s.mem_data;
        if (s.wb_wen  && s.wb_addr  == a) return s.wb_data;
        return rf;
    endfunction

    function automatic logic m_hz();
        return s.valid && s.ex_wen && s.ex_load && s.ex_addr != 0 &&
               ((s.rs_used && s.rs == s.ex_addr) || (s.rt_used && s.rt == s.ex_addr));
    endfunction

    function automatic logic m_ready();
        return !rst && (s.flush || (!s.hold && !m_hz()));
    endfunction

    task automatic model_update();
        int sa_int;
        sa_int = int'(s.sa);
        if (rst) begin
            m_valid = 0; m_op1 = 0; m_op1s = 0; m_op2 = 0; m_sd = 0;
            m_dst = 0; m_wen = 0; m_wsrc = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (s.flush) begin
            m_valid = 0;
        end else if (s.hold) begin
            m_valid = m_valid;
        end else if (m_hz()) begin
            m_valid = 0;
            if (m_cnt0 < 65535) m_cnt0++;
            if (m_cnt1 < 3) m_cnt1++;
        end else begin
            m_valid = s.valid;
            m_op1   = s.op1_src ? 32'(sa_int) : m_fwd(s.rs, s.rs_d);
            m_op1s  = s.op1_src ? ((sa_int >= 16) ? 32'(sa_int - 32) : 32'(sa_int))
                                : m_fwd(s.rs, s.rs_d);
            m_op2   = s.op2_src ? s.imm : m_fwd(s.rt, s.rt_d);
            m_sd    = m_fwd(s.rt, s.rt_d);
            case (s.dst_src)
                2'd0: m_dst = s.rt;
                2'd1: m_dst = s.rd;
                2'd2: m_dst = 5'd31;
                default: m_dst = 5'd0;
            endcase
            m_wen   = s.reg_wen && s.dst_src != 2'd3;
            m_wsrc  = s.wsrc;
        end
    endtask

    task automatic cmp_model();
        chk("valid0", 32'(bus0.ex_valid_o), 32'(m_valid));
        chk("opnd1_0", bus0.ex_opnd1_o, m_op1);
        chk("opnd2_0", bus0.ex_opnd2_o, m_op2);
        chk("sdata0", bus0.ex_store_data_o, m_sd);
        chk("dst0", 32'(bus0.ex_reg_dst_o), 32'(m_dst));
        chk("rwen0", 32'(bus0.ex_reg_wen_o), 32'(m_wen));
        chk("wsrc0", 32'(bus0.ex_wdata_src_o), 32'(m_wsrc));
        chk("stall0", 32'(bus0.stall_cnt_o), 32'(m_cnt0));
        chk("valid1", 32'(bus1.ex_valid_o), 32'(m_valid));
        chk("opnd1_1", bus1.ex_opnd1_o, m_op1s);
        chk("opnd2_1", bus1.ex_opnd2_o, m_op2);
        chk("stall1", 32'(bus1.stall_cnt_o), 32'(m_cnt1));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step(input int exp_ready);
        logic r;
        #1;
        r = m_ready();
        chk("ready0", 32'(bus0.id_ready_o), 32'(r));
        chk("ready1", 32'(bus1.id_ready_o), 32'(r));
        if (exp_ready >= 0) chk("ready_exp", 32'(bus0.id_ready_o), 32'(exp_ready));
        model_update();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    function automatic stim_t base();
        stim_t b;
        b = '{valid: 1'b1, rs: 5'd1, rt: 5'd9, rd: 5'd7, rs_d: 32'h44, rt_d: 32'h55,
              rs_used: 1'b1, rt_used: 1'b1, sa: 5'd0, imm: 32'h0, op1_src: 1'b0, op2_src: 1'b0,
              dst_src: 2'd1, wsrc: 2'd2, reg_wen: 1'b1,
              ex_wen: 1'b0, ex_addr: 5'd0, ex_data: 32'h11, ex_load: 1'b0,
              mem_wen: 1'b0, mem_addr: 5'd0, mem_data: 32'h22,
              wb_wen: 1'b0, wb_addr: 5'd0, wb_data: 32'h33, hold: 1'b0, flush: 1'b0};
        return b;
    endfunction

    typedef struct {
        logic [4:0]  rs, rt;
        logic        op1_src, op2_src;
        logic [4:0]  sa;
        logic [31:0] imm;
        logic [1:0]  dst;
        logic        rwen;
        logic [2:0]  fw;      // {ex, mem, wb} write enables
        logic [4:0]  faddr;
        logic [31:0] e_op1, e_op1s, e_op2;
        logic [4:0]  e_dst;
        logic        e_wen;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{5'd3, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b1, 3'b111, 5'd3, 32'h11, 32'h11, 32'h55, 5'd7, 1'b1};
        tv[1]  = '{5'd3, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b1, 3'b011, 5'd3, 32'h22, 32'h22, 32'h55, 5'd7, 1'b1};
        tv[2]  = '{5'd3, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b1, 3'b001, 5'd3, 32'h33, 32'h33, 32'h55, 5'd7, 1'b1};
        tv[3]  = '{5'd3, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b1, 3'b000, 5'd3, 32'h44, 32'h44, 32'h55, 5'd7, 1'b1};
        tv[4]  = '{5'd0, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b1, 3'b100, 5'd0, 32'h00, 32'h00, 32'h55, 5'd7, 1'b1};
        tv[5]  = '{5'd3, 5'd9, 1'b1, 1'b0, 5'h1F, 32'h0, 2'd1, 1'b1, 3'b000, 5'd3, 32'h1F, 32'hFFFFFFFF, 32'h55, 5'd7, 1'b1};
        tv[6]  = '{5'd3, 5'd9, 1'b1, 1'b0, 5'h0F, 32'h0, 2'd1, 1'b1, 3'b000, 5'd3, 32'h0F, 32'h0F, 32'h55, 5'd7, 1'b1};
        tv[7]  = '{5'd3, 5'd9, 1'b0, 1'b1, 5'h00, 32'hDEADBEEF, 2'd1, 1'b1, 3'b000, 5'd3, 32'h44, 32'h44, 32'hDEADBEEF, 5'd7, 1'b1};
        tv[8]  = '{5'd1, 5'd3, 1'b0, 1'b0, 5'h00, 32'h0, 2'd0, 1'b1, 3'b010, 5'd3, 32'h44, 32'h44, 32'h22, 5'd3, 1'b1};
        tv[9]  = '{5'd1, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd2, 1'b1, 3'b000, 5'd3, 32'h44, 32'h44, 32'h55, 5'd31, 1'b1};
        tv[10] = '{5'd1, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd3, 1'b1, 3'b000, 5'd3, 32'h44, 32'h44, 32'h55, 5'd0, 1'b0};
        tv[11] = '{5'd1, 5'd9, 1'b0, 1'b0, 5'h00, 32'h0, 2'd1, 1'b0, 3'b000, 5'd3, 32'h44, 32'h44, 32'h55, 5'd7, 1'b0};

        rst = 1'b1;
        s = base();
        s.valid = 1'b0;
        @(negedge clk);

        // reset for two cycles
        for (int i = 0; i < 2; i++) begin
            step(0);
            chk("rst_valid", 32'(bus0.ex_valid_o), 32'h0);
            chk("rst_stall", 32'(bus0.stall_cnt_o), 32'h0);
            chk("rst_opnd1", bus0.ex_opnd1_o, 32'h0);
            chk("rst_dst", 32'(bus0.ex_reg_dst_o), 32'h0);
        end
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            s = base();
            s.rs = tv[i].rs; s.rt = tv[i].rt;
            s.op1_src = tv[i].op1_src; s.op2_src = tv[i].op2_src;
            s.sa = tv[i].sa; s.imm = tv[i].imm;
            s.dst_src = tv[i].dst; s.reg_wen = tv[i].rwen;
            s.ex_wen = tv[i].fw[2]; s.mem_wen = tv[i].fw[1]; s.wb_wen = tv[i].fw[0];
            s.ex_addr = tv[i].faddr; s.mem_addr = tv[i].faddr; s.wb_addr = tv[i].faddr;
            step(1);
            chk($sformatf("v%0d_op1", i), bus0.ex_opnd1_o, tv[i].e_op1);
            chk($sformatf("v%0d_op1s", i), bus1.ex_opnd1_o, tv[i].e_op1s);
            chk($sformatf("v%0d_op2", i), bus0.ex_opnd2_o, tv[i].e_op2);
            chk($sformatf("v%0d_dst", i), 32'(bus0.ex_reg_dst_o), 32'(tv[i].e_dst));
            chk($sformatf("v%0d_wen", i), 32'(bus0.ex_reg_wen_o), 32'(tv[i].e_wen));
            chk($sformatf("v%0d_valid", i), 32'(bus0.ex_valid_o), 32'h1);
        end

        // load-use: bubble, then retry forwarding from MEM
        rst = 1'b1; s = base(); s.valid = 1'b0; step(0); rst = 1'b0;
        s = base(); s.rt = 5'd5;
        s.ex_wen = 1'b1; s.ex_addr = 5'd5; s.ex_load = 1'b1; s.ex_data = 32'h999;
        step(0);
        chk("lu_bubble_valid", 32'(bus0.ex_valid_o), 32'h0);
        chk("lu_stall0", 32'(bus0.stall_cnt_o), 32'h1);
        chk("lu_stall1", 32'(bus1.stall_cnt_o), 32'h1);
        s.ex_wen = 1'b0; s.ex_load = 1'b0;
        s.mem_wen = 1'b1; s.mem_addr = 5'd5; s.mem_data = 32'hABCD;
        step(1);
        chk("lu_retry_valid", 32'(bus0.ex_valid_o), 32'h1);
        chk("lu_retry_op2", bus0.ex_opnd2_o, 32'hABCD);
        chk("lu_retry_sd", bus0.ex_store_data_o, 32'hABCD);

        // hold three cycles with changing inputs
        s.hold = 1'b1; s.mem_wen = 1'b0; s.rt_d = 32'h1234; s.rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("hold_op2", bus0.ex_opnd2_o, 32'hABCD);
            chk("hold_valid", 32'(bus0.ex_valid_o), 32'h1);
            chk("hold_dst", 32'(bus0.ex_reg_dst_o), 32'd7);
        end
        // hazard under hold: hold wins, counter unchanged
        s.ex_wen = 1'b1; s.ex_addr = 5'd5; s.ex_load = 1'b1;
        step(0);
        chk("hzhold_stall", 32'(bus0.stall_cnt_o), 32'h1);
        chk("hzhold_valid", 32'(bus0.ex_valid_o), 32'h1);
        // flush with hold
        s.flush = 1'b1;
        step(1);
        chk("flush_valid", 32'(bus0.ex_valid_o), 32'h0);
        chk("flush_op2", bus0.ex_opnd2_o, 32'hABCD);
        // reset in the middle of a stall
        s.flush = 1'b0; s.hold = 1'b0;
        step(0);
        chk("stall2", 32'(bus0.stall_cnt_o), 32'h2);
        rst = 1'b1;
        step(0);
        chk("rststall_cnt", 32'(bus0.stall_cnt_o), 32'h0);
        chk("rststall_valid", 32'(bus0.ex_valid_o), 32'h0);
        rst = 1'b0;
        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) step(0);
        chk("sat_cnt0", 32'(bus0.stall_cnt_o), 32'd5);
        chk("sat_cnt1", 32'(bus1.stall_cnt_o), 32'd3);
        s.ex_wen = 1'b0;
        step(1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            s.valid   = ($urandom_range(0, 5) != 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 31));
            s.rs_d    = $urandom;  s.rt_d = $urandom;
            s.rs_used = 1'($urandom); s.rt_used = 1'($urandom);
            s.sa      = 5'($urandom); s.imm = $urandom;
            s.op1_src = 1'($urandom); s.op2_src = 1'($urandom);
            s.dst_src = 2'($urandom); s.wsrc = 2'($urandom); s.reg_wen = 1'($urandom);
            s.ex_wen  = 1'($urandom); s.ex_addr = 5'($urandom_range(0, 3));
            s.ex_data = $urandom;     s.ex_load = ($urandom_range(0, 2) == 0);
            s.mem_wen = 1'($urandom); s.mem_addr = 5'($urandom_range(0, 3)); s.mem_data = $urandom;
            s.wb_wen  = 1'($urandom); s.wb_addr = 5'($urandom_range(0, 3));  s.wb_data = $urandom;
            s.hold    = ($urandom_range(0, 5) == 0);
            s.flush   = ($urandom_range(0, 7) == 0);
            step(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
